// File: rtl/vga_pkg.sv
// ============================================================================
// Module      : vga_pkg
// Description : 640x480@60 default timing constants and the span-to-maximum
//               helper shared by the VGA timing generator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_pkg;

    localparam int c_CLK_DIV_DEF = 4;

    localparam int c_HD_DEF = 640;
    localparam int c_HF_DEF = 16;
    localparam int c_HR_DEF = 96;
    localparam int c_HB_DEF = 48;

    localparam int c_VD_DEF = 480;
    localparam int c_VF_DEF = 10;
    localparam int c_VR_DEF = 2;
    localparam int c_VB_DEF = 33;

    // Last counter value of a display/porch/sync/porch sequence.
    function automatic int calc_max(input int disp, input int fp, input int sync, input int bp);
        return disp + fp + sync + bp - 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pix_tick_div.sv
// ============================================================================
// Module      : pix_tick_div
// Description : Enable-gated clk_100MHz divider producing a one-cycle pixel
//               strobe every CLK_DIV enabled cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pix_tick_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk_100MHz,
    input  logic reset,
    input  logic en,
    output logic p_tick
);

    generate
        if (CLK_DIV < 1) begin : g_bad_div
            $error("pix_tick_div: CLK_DIV must be at least 1");
        end

        if (CLK_DIV <= 1) begin : g_passthru
            // Every enabled cycle is a pixel; clock and reset carry no state here.
            logic w_unused;
            assign w_unused = clk_100MHz ^ reset;
            assign p_tick   = en;
        end else begin : g_count
            localparam int              c_DW   = $clog2(CLK_DIV);
            localparam logic [c_DW-1:0] c_LAST = c_DW'(CLK_DIV - 1);

            logic [c_DW-1:0] r_div;

            always_ff @(posedge clk_100MHz) begin
                if (reset) begin
                    r_div <= '0;
                end else if (en) begin
                    r_div <= (r_div == c_LAST) ? '0 : r_div + 1'b1;
                end
            end

            assign p_tick = en && (r_div == c_LAST);
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/vga_timing_gen.sv
// ============================================================================
// Module      : vga_timing_gen
// Description : VGA raster timing: pixel strobe, x/y counters, registered
//               video_on/hsync/vsync and line/frame start pulses.
//               Define VGA_TIMING_GEN_FRAME_CNT_EN to add a 16-bit frame_count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   CLK_DIV   = c_CLK_DIV_DEF,
    parameter int   HD        = c_HD_DEF,
    parameter int   HF        = c_HF_DEF,
    parameter int   HR        = c_HR_DEF,
    parameter int   HB        = c_HB_DEF,
    parameter int   VD        = c_VD_DEF,
    parameter int   VF        = c_VF_DEF,
    parameter int   VR        = c_VR_DEF,
    parameter int   VB        = c_VB_DEF,
    parameter logic HSYNC_POL = 1'b0,
    parameter logic VSYNC_POL = 1'b0,
    parameter int   CW        = 11
) (
    input  logic          clk_100MHz,
    input  logic          reset,
    input  logic          en,
    output logic          p_tick,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          video_on,
    output logic          hsync,
    output logic          vsync,
    output logic          line_start,
    output logic          frame_start
`ifdef VGA_TIMING_GEN_FRAME_CNT_EN
    ,
    output logic [15:0]   frame_count
`endif
);

    localparam int c_HMAX_I = calc_max(HD, HF, HR, HB);
    localparam int c_VMAX_I = calc_max(VD, VF, VR, VB);

    generate
        if ((c_HMAX_I >= (1 << CW)) || (c_VMAX_I >= (1 << CW))) begin : g_bad_cw
            $error("vga_timing_gen: HMAX/VMAX do not fit in CW bits");
        end
    endgenerate

    localparam logic [CW-1:0] c_HMAX     = CW'(c_HMAX_I);
    localparam logic [CW-1:0] c_VMAX     = CW'(c_VMAX_I);
    localparam logic [CW-1:0] c_HD       = CW'(HD);
    localparam logic [CW-1:0] c_VD       = CW'(VD);
    localparam logic [CW-1:0] c_HS_FIRST = CW'(HD + HF);
    localparam logic [CW-1:0] c_HS_LAST  = CW'(HD + HF + HR - 1);
    localparam logic [CW-1:0] c_VS_FIRST = CW'(VD + VF);
    localparam logic [CW-1:0] c_VS_LAST  = CW'(VD + VF + VR - 1);

    logic          w_tick;
    logic          w_x_last;
    logic          w_y_last;
    logic          w_hs_active;
    logic          w_vs_active;
    logic [CW-1:0] r_x;
    logic [CW-1:0] r_y;
    logic          r_video_on;
    logic          r_hsync;
    logic          r_vsync;

    pix_tick_div #(
        .CLK_DIV (CLK_DIV)
    ) u_pix_tick_div (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .en         (en),
        .p_tick     (w_tick)
    );

    assign w_x_last    = (r_x == c_HMAX);
    assign w_y_last    = (r_y == c_VMAX);
    assign w_hs_active = (r_x >= c_HS_FIRST) && (r_x <= c_HS_LAST);
    assign w_vs_active = (r_y >= c_VS_FIRST) && (r_y <= c_VS_LAST);

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            r_x <= '0;
            r_y <= '0;
        end else if (w_tick) begin
            r_x <= w_x_last ? '0 : r_x + 1'b1;
            if (w_x_last) begin
                r_y <= w_y_last ? '0 : r_y + 1'b1;
            end
        end
    end

    // Decoded every clock from the current count, so these trail x/y by one cycle.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            r_video_on <= 1'b0;
            r_hsync    <= ~HSYNC_POL;
            r_vsync    <= ~VSYNC_POL;
        end else begin
            r_video_on <= (r_x < c_HD) && (r_y < c_VD);
            r_hsync    <= w_hs_active ? HSYNC_POL : ~HSYNC_POL;
            r_vsync    <= w_vs_active ? VSYNC_POL : ~VSYNC_POL;
        end
    end

    assign p_tick      = w_tick;
    assign x           = r_x;
    assign y           = r_y;
    assign video_on    = r_video_on;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign line_start  = w_tick && w_x_last;
    assign frame_start = line_start && w_y_last;

`ifdef VGA_TIMING_GEN_FRAME_CNT_EN
    logic [15:0] r_frame_count;

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            r_frame_count <= '0;
        end else if (frame_start) begin
            r_frame_count <= r_frame_count + 16'd1;
        end
    end

    assign frame_count = r_frame_count;
`endif

endmodule

`default_nettype wire

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, meaning clk_100MHz cycles per pixel (≥1).
REQ-002 SHALL have parameters HD, HF, HR, HB with defaults 640, 16, 96, 48, meaning horizontal display, front porch, sync and back porch widths in pixels.
REQ-003 SHALL have parameters VD, VF, VR, VB with defaults 480, 10, 2, 33, meaning the vertical equivalents in lines.
REQ-004 SHALL have parameters HSYNC_POL and VSYNC_POL, default 0 each, meaning the active sync level.
REQ-005 SHALL have parameter CW, default 11, meaning the x/y counter width.
REQ-006 SHALL have ports in this order: clk_100MHz input 1 (sole clock); reset input 1 (synchronous, active-high); en input 1 (timing run enable); p_tick output 1 (pixel strobe); x output CW (horizontal count); y output CW (vertical count); video_on output 1; hsync output 1; vsync output 1; line_start output 1; frame_start output 1.

Function
REQ-007 SHALL run a divider counting 0..CLK_DIV-1 while en=1, wrapping to 0 after CLK_DIV-1, and holding while en=0.
REQ-008 SHALL drive p_tick combinationally high when the divider equals CLK_DIV-1 and en=1; with CLK_DIV=1, p_tick SHALL equal en.
REQ-009 SHALL advance x only on clk_100MHz edges where p_tick=1, with HMAX=HD+HF+HR+HB-1 and x wrapping HMAX→0.
REQ-010 SHALL advance y by 1 only when p_tick=1 and x=HMAX, with VMAX=VD+VF+VR+VB-1, y wrapping VMAX→0, and y otherwise holding.
REQ-011 SHALL register video_on, hsync and vsync every clk_100MHz edge from the current x/y, so they lag x/y by exactly one clk cycle.
REQ-012 SHALL assert video_on when x<HD and y<VD.
REQ-013 SHALL drive hsync to HSYNC_POL when HD+HF ≤ x ≤ HD+HF+HR-1, and to ~HSYNC_POL otherwise.
REQ-014 SHALL drive vsync to VSYNC_POL when VD+VF ≤ y ≤ VD+VF+VR-1, and to ~VSYNC_POL otherwise.
REQ-015 SHALL make line_start a combinational one-cycle pulse equal to p_tick AND x=HMAX.
REQ-016 SHALL make frame_start a combinational pulse equal to line_start AND y=VMAX.
REQ-017 SHALL, when en is deasserted mid-line, freeze x, y, the divider and the registered outputs' source values; timing SHALL resume from the same point when en returns.
REQ-018 SHALL perform all arithmetic at CW bits; HMAX and VMAX SHALL each be < 2**CW, and the design SHALL fail elaboration otherwise.

Reset
REQ-019 SHALL, while reset=1 at a clk edge, load divider=0, x=0, y=0, video_on=0, hsync=~HSYNC_POL and vsync=~VSYNC_POL; reset SHALL take priority over en.
REQ-020 SHALL make the first p_tick after reset release occur on the CLK_DIV-th enabled cycle.
REQ-021 SHALL return all state to reset values on the next edge when reset is asserted mid-frame, with no partial-line completion.

Configuration
REQ-022 SHALL, with macro VGA_TIMING_GEN_FRAME_CNT_EN defined, add output frame_count (16 bits, reset 0) that increments on each frame_start and wraps 65535→0.
REQ-023 SHALL, without VGA_TIMING_GEN_FRAME_CNT_EN, not have the frame_count port or register, leaving all other behaviour identical.

Structure
REQ-024 SHALL place the default timing constants (640x480@60 set) and a function computing HMAX/VMAX in shared package vga_pkg.
REQ-025 SHALL implement the divider as sub-module pix_tick_div (parameter CLK_DIV; ports clk_100MHz, reset, en, p_tick).

Verification
REQ-026 Reset then en=1 with defaults -> p_tick high on cycles 4, 8, 12…; x=1 after the first tick.
REQ-027 Defaults, run one full frame -> exactly 1,680,000 clk cycles between frame_start pulses; 525 line_start pulses per frame.
REQ-028 Defaults -> hsync=0 exactly while x=656..751 (lagged one clk); vsync=0 exactly while y=490..491; video_on=0 at x=640.
REQ-029 en=0 for 37 cycles at x=300 -> x, y and divider unchanged; the next p_tick comes CLK_DIV-d enabled cycles later, where d is the divider value at freeze.
REQ-030 Reset asserted at x=700, y=495 -> next edge x=0, y=0, hsync=1, vsync=1, video_on=0; frame_count=0 with the macro defined.
REQ-031 CLK_DIV=1, HSYNC_POL=1, 10x4 tiny timing (HD=4, HF=HR=HB=2, VD=2, VF=VR=VB=1) -> line every 10 cycles, frame every 50, hsync high at x=6..7.
